// File: rtl/data_bus_sink_if.sv
// Valid/data bus into the sink plus the valid/ready handshake out of it.
// The master side drives the bus and consumes the output; the slave side is the sink.
interface data_bus_sink_if #(
    parameter int BusWidth = 32
);
    logic                in_valid;
    logic [BusWidth-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [BusWidth-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/data_bus_sink.sv
// Receive end of the valid/data bus: buffers every offered word in a FIFO,
// re-presents it on valid/ready, and counts words lost when the FIFO is full.
module data_bus_sink #(
    parameter int BusWidth = 32,
    parameter int Depth    = 8,
    parameter int CntWidth = 16,
    localparam int LvlW    = $clog2(Depth + 1),
    localparam int PtrW    = $clog2(Depth)
) (
    input  logic                clk,
    input  logic                rst_n,
    data_bus_sink_if.slave      bus,
    output logic [LvlW-1:0]     level,
    output logic                overflow,
    output logic [CntWidth-1:0] drop_count,
    input  logic                clr_overflow
);

    logic [BusWidth-1:0] mem [Depth];
    logic [PtrW-1:0]     wr_ptr;
    logic [PtrW-1:0]     rd_ptr;
    logic [PtrW-1:0]     rd_next;
    logic [LvlW-1:0]     remain;
    logic [BusWidth-1:0] out_data_q;
    logic                full;
    logic                pop;
    logic                push;
    logic                drop;

    assign full    = (level == LvlW'(Depth));
    assign pop     = bus.out_valid & bus.out_ready;
    assign push    = bus.in_valid & (~full | pop);
    assign drop    = bus.in_valid & full & ~pop;
    assign rd_next = pop ? rd_ptr + PtrW'(1) : rd_ptr;
    assign remain  = level - LvlW'(pop);

    assign bus.out_valid = (level != '0);
    assign bus.out_data  = out_data_q;

    // Storage needs no reset: every slot is written before it can be read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            out_data_q <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            rd_ptr <= rd_next;

            if (push && !pop) begin
                level <= level + LvlW'(1);
            end else if (pop && !push) begin
                level <= level - LvlW'(1);
            end

            // Head register: the word being written now becomes the head only
            // when nothing older remains; otherwise read the next stored word.
            if (remain == '0) begin
                if (push) begin
                    out_data_q <= bus.in_data;
                end
            end else begin
                out_data_q <= mem[rd_next];
            end

            // A clear coinciding with a drop still records that drop.
            if (clr_overflow) begin
                overflow   <= drop;
                drop_count <= drop ? CntWidth'(1) : '0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + CntWidth'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_data_bus_sink.sv
// Directed bench for data_bus_sink: a queue-based reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_data_bus_sink;

    localparam int BusWidth = 32;
    localparam int Depth    = 8;
    localparam int CntWidth = 4;
    localparam int LvlW     = $clog2(Depth + 1);
    localparam logic [CntWidth-1:0] CntMax = '1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                clr_overflow;
    logic [LvlW-1:0]     level;
    logic                overflow;
    logic [CntWidth-1:0] drop_count;

    int errors = 0;
    int checks = 0;

    data_bus_sink_if #(.BusWidth(BusWidth)) bus ();

    data_bus_sink #(
        .BusWidth (BusWidth),
        .Depth    (Depth),
        .CntWidth (CntWidth)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .level        (level),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of accepted words plus drop bookkeeping.
    logic [BusWidth-1:0] q [$];
    int                  m_drops;
    logic                m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_drops = 0;
            m_ovf   = 1'b0;
        end else begin
            automatic bit do_pop  = bus.out_ready && (q.size() > 0);
            automatic bit do_drop = bus.in_valid && (q.size() == Depth) && !do_pop;
            if (do_pop) void'(q.pop_front());
            if (bus.in_valid && !do_drop) q.push_back(bus.in_data);
            if (clr_overflow) begin
                m_ovf   = do_drop;
                m_drops = do_drop ? 1 : 0;
            end else if (do_drop) begin
                m_ovf = 1'b1;
                if (m_drops < int'(CntMax)) m_drops++;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
        chk("m_level", 64'(level), 64'(q.size()));
        chk("m_overflow", 64'(overflow), 64'(m_ovf));
        chk("m_drop_count", 64'(drop_count), 64'(m_drops));
        if (q.size() > 0) chk("m_out_data", 64'(bus.out_data), 64'(q[0]));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input logic [BusWidth-1:0] base);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = base + BusWidth'(i);
            step();
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 'x;
    endtask

    logic [BusWidth-1:0] drain_exp [8];

    initial begin
        drain_exp = '{32'h14, 32'h15, 32'h16, 32'h17, 32'h20, 32'h21, 32'h22, 32'h23};
        rst_n        = 1'b0;
        clr_overflow = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 'x;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        rst_n = 1'b1;
        step();

        // Single word with a ready consumer.
        bus.out_ready = 1'b1;
        push_n(1, 32'hA5A5_0001);
        chk("single_valid", 64'(bus.out_valid), 64'd1);
        chk("single_data", 64'(bus.out_data), 64'hA5A5_0001);
        step();
        chk("single_level_after", 64'(level), 64'd0);
        chk("single_valid_after", 64'(bus.out_valid), 64'd0);

        // Fill with the consumer stalled.
        bus.out_ready = 1'b0;
        push_n(8, 32'h10);
        chk("fill_level", 64'(level), 64'd8);
        chk("fill_overflow", 64'(overflow), 64'd0);
        chk("fill_head", 64'(bus.out_data), 64'h10);

        // Three words offered while full are dropped.
        push_n(3, 32'hDEAD_0000);
        chk("ovf_drops", 64'(drop_count), 64'd3);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_head", 64'(bus.out_data), 64'h10);
        chk("ovf_level", 64'(level), 64'd8);

        // Full with simultaneous pop: no drops.
        bus.out_ready = 1'b1;
        push_n(4, 32'h20);
        chk("fullpop_level", 64'(level), 64'd8);
        chk("fullpop_drops", 64'(drop_count), 64'd3);

        for (int i = 0; i < 8; i++) begin
            chk("drain_data", 64'(bus.out_data), 64'(drain_exp[i]));
            step();
        end
        chk("drain_level", 64'(level), 64'd0);
        chk("drain_valid", 64'(bus.out_valid), 64'd0);

        // Build drop_count=5, then clear in the same cycle as a drop.
        bus.out_ready = 1'b0;
        clr_overflow  = 1'b1;
        step();
        clr_overflow = 1'b0;
        chk("clr0_drops", 64'(drop_count), 64'd0);
        push_n(8, 32'h30);
        push_n(5, 32'h40);
        chk("pre_clr_drops", 64'(drop_count), 64'd5);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h50;
        clr_overflow = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("coll_overflow", 64'(overflow), 64'd1);
        chk("coll_drops", 64'(drop_count), 64'd1);
        step();
        clr_overflow = 1'b0;
        chk("clr_overflow", 64'(overflow), 64'd0);
        chk("clr_drops", 64'(drop_count), 64'd0);

        // Counter saturation.
        push_n(20, 32'h60);
        chk("sat_drops", 64'(drop_count), 64'(CntMax));
        chk("sat_head", 64'(bus.out_data), 64'h30);

        // Reset mid-stream: level 5 with pushes ongoing.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
        push_n(5, 32'h70);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h7F;
        chk("mid_level5", 64'(level), 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_level", 64'(level), 64'd0);
        chk("mid_rst_data", 64'(bus.out_data), 64'd0);
        chk("mid_rst_ovf", 64'(overflow), 64'd0);
        chk("mid_rst_drops", 64'(drop_count), 64'd0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        step();
        chk("post_rst_valid", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;
        push_n(1, 32'h55);
        chk("post_rst_data", 64'(bus.out_data), 64'h55);
        chk("post_rst_level", 64'(level), 64'd1);
        step();
        chk("post_rst_empty", 64'(bus.out_valid), 64'd0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
